pio_command_issuer: RTL and testbench

LVDC-side initiator for PIO commands consumed by the LVDA address-decode latches.
- Accepts one command at a time via valid/ready.
- Drives the dual-rail address lines A3..A7 (DV/DVN pairs) and the group-select lines for one full word time.
- Fires exactly one timing strobe (X3, W8 or Y8) at a fixed bit/phase slot.
- Reports completion with a one-cycle done pulse.

---
 rtl/pio_issuer_pkg.sv | 50 +++++
 rtl/pio_command_issuer_word_timer.sv | 79 +++++++
 rtl/pio_command_issuer.sv | 133 +++++++++++++
 tb/tb_pio_command_issuer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pio_issuer_pkg.sv
// rtl/pio_issuer_pkg.sv - shared types and strobe slot constants for the PIO command issuer
package pio_issuer_pkg;

  typedef enum logic [1:0] {
    OP_LATCH   = 2'd0,
    OP_DARA_WR = 2'd1,
    OP_DARO_WR = 2'd2,
    OP_CLEAR   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    PH_W = 2'd0,
    PH_X = 2'd1,
    PH_Y = 2'd2,
    PH_Z = 2'd3
  } phase_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam int     X3_BIT   = 3;
  localparam phase_e X3_PHASE = PH_X;
  localparam int     W8_BIT   = 8;
  localparam phase_e W8_PHASE = PH_W;
  localparam int     Y8_BIT   = 8;
  localparam phase_e Y8_PHASE = PH_Y;

  typedef struct packed {
    logic lgav;
    logic pcg2v;
    logic dara;
    logic daro;
    logic parsv;
  } sel_t;

  function automatic sel_t decode_sel(op_e op);
    sel_t s;
    s = '0;
    case (op)
      OP_LATCH:   begin s.lgav = 1'b1; s.pcg2v = 1'b1; end
      OP_DARA_WR: s.dara  = 1'b1;
      OP_DARO_WR: s.daro  = 1'b1;
      OP_CLEAR:   s.parsv = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pio_command_issuer_word_timer.sv
// rtl/pio_command_issuer_word_timer.sv - phase-cycle / phase / bit counters for one word time
module pio_word_timer
  import pio_issuer_pkg::*;
#(
  parameter int PHASE_CYCLES = 1,
  parameter int NUM_BITS     = 14,
  localparam int BW = $clog2(NUM_BITS + 1),
  localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clear,
  output logic          run_nxt,
  output logic [BW-1:0] bit_nxt,
  output logic [1:0]    phase_nxt,
  output logic          last_cycle
);

  logic          running;
  logic [PW-1:0] pcnt, pcnt_nxt;
  phase_e        phase, phase_n;
  logic [BW-1:0] bit_cnt;

  assign last_cycle = running && (pcnt == PW'(PHASE_CYCLES - 1)) &&
                      (phase == PH_Z) && (bit_cnt == BW'(NUM_BITS));
  assign phase_nxt  = phase_n;

  // The *_nxt view is the position being entered, so the top can register outputs aligned to it
  always_comb begin
    run_nxt  = running;
    pcnt_nxt = pcnt;
    phase_n  = phase;
    bit_nxt  = bit_cnt;
    if (clear) begin
      run_nxt  = 1'b0;
      pcnt_nxt = '0;
      phase_n  = PH_W;
      bit_nxt  = '0;
    end else if (start) begin
      run_nxt  = 1'b1;
      pcnt_nxt = '0;
      phase_n  = PH_W;
      bit_nxt  = BW'(1);
    end else if (running) begin
      if (pcnt == PW'(PHASE_CYCLES - 1)) begin
        pcnt_nxt = '0;
        if (phase == PH_Z) begin
          phase_n = PH_W;
          if (last_cycle) begin
            run_nxt = 1'b0;
            bit_nxt = '0;
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end else begin
          phase_n = phase_e'(phase + 2'd1);
        end
      end else begin
        pcnt_nxt = pcnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      pcnt    <= '0;
      phase   <= PH_W;
      bit_cnt <= '0;
    end else begin
      running <= run_nxt;
      pcnt    <= pcnt_nxt;
      phase   <= phase_n;
      bit_cnt <= bit_nxt;
    end
  end

endmodule

// File: rtl/pio_command_issuer.sv
// rtl/pio_command_issuer.sv - LVDC-side PIO command issuer driving LVDA address-decode latches
module pio_command_issuer
  import pio_issuer_pkg::*;
#(
  parameter int PHASE_CYCLES = 1,
  parameter int NUM_BITS     = 14
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_addr,
  input  logic       cmd_abort,
  output logic       V1,
  output logic       A3DV,
  output logic       A4DV,
  output logic       A5DV,
  output logic       A6DV,
  output logic       A7DV,
  output logic       A3DVN,
  output logic       A4DVN,
  output logic       A5DVN,
  output logic       A6DVN,
  output logic       A7DVN,
  output logic       LGAV,
  output logic       PCG2V,
  output logic       DARA,
  output logic       DARO,
  output logic       PARSV,
  output logic       X3,
  output logic       W8,
  output logic       Y8,
  output logic       done,
  output logic       aborted
);

  localparam int BW = $clog2(NUM_BITS + 1);

  state_e        state;
  op_e           op_q, op_eff;
  logic          v1_pre;
  logic [4:0]    dv_q, dvn_q;
  sel_t          sel_q;
  logic          x3_q, w8_q, y8_q;
  logic          accept, abort_now;
  logic          tm_run_nxt, tm_last;
  logic [BW-1:0] tm_bit;
  logic [1:0]    tm_phase;
  logic          hit_x3, hit_w8, hit_y8;

  assign cmd_ready = (state == ST_IDLE) && V1;
  assign accept    = cmd_valid && cmd_ready;
  assign abort_now = (state == ST_ACTIVE) && cmd_abort;
  assign op_eff    = (state == ST_IDLE) ? op_e'(cmd_op) : op_q;

  pio_word_timer #(
    .PHASE_CYCLES (PHASE_CYCLES),
    .NUM_BITS     (NUM_BITS)
  ) u_timer (
    .clk        (SIM_CLK),
    .rst_n      (SIM_RST),
    .start      (accept),
    .clear      (abort_now),
    .run_nxt    (tm_run_nxt),
    .bit_nxt    (tm_bit),
    .phase_nxt  (tm_phase),
    .last_cycle (tm_last)
  );

  // Strobe decode looks at the slot being entered so the registered strobe lines up with it
  assign hit_x3 = tm_run_nxt && (op_eff == OP_LATCH) &&
                  (tm_bit == BW'(X3_BIT)) && (phase_e'(tm_phase) == X3_PHASE);
  assign hit_w8 = tm_run_nxt && ((op_eff == OP_DARA_WR) || (op_eff == OP_CLEAR)) &&
                  (tm_bit == BW'(W8_BIT)) && (phase_e'(tm_phase) == W8_PHASE);
  assign hit_y8 = tm_run_nxt && (op_eff == OP_DARO_WR) &&
                  (tm_bit == BW'(Y8_BIT)) && (phase_e'(tm_phase) == Y8_PHASE);

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state   <= ST_IDLE;
      op_q    <= OP_LATCH;
      v1_pre  <= 1'b0;
      V1      <= 1'b0;
      dv_q    <= '0;
      dvn_q   <= '0;
      sel_q   <= '0;
      x3_q    <= 1'b0;
      w8_q    <= 1'b0;
      y8_q    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      v1_pre  <= 1'b1;
      V1      <= v1_pre;
      done    <= 1'b0;
      aborted <= 1'b0;
      x3_q    <= hit_x3;
      w8_q    <= hit_w8;
      y8_q    <= hit_y8;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_ACTIVE;
            op_q  <= op_e'(cmd_op);
            dv_q  <= cmd_addr;
            dvn_q <= ~cmd_addr;
            sel_q <= decode_sel(op_e'(cmd_op));
          end
        end
        ST_ACTIVE: begin
          // Abort wins over a word end landing in the same cycle
          if (cmd_abort || tm_last) begin
            state   <= ST_IDLE;
            dv_q    <= '0;
            dvn_q   <= '0;
            sel_q   <= '0;
            aborted <= cmd_abort;
            done    <= !cmd_abort;
          end
        end
      endcase
    end
  end

  assign {A7DV, A6DV, A5DV, A4DV, A3DV}      = dv_q;
  assign {A7DVN, A6DVN, A5DVN, A4DVN, A3DVN} = dvn_q;
  assign {LGAV, PCG2V, DARA, DARO, PARSV}    = sel_q;
  assign X3 = x3_q;
  assign W8 = w8_q;
  assign Y8 = y8_q;

endmodule

// File: tb/tb_pio_command_issuer.sv
// tb/tb_pio_command_issuer.sv - scoreboard bench for pio_command_issuer
module tb_pio_command_issuer;

  localparam int NB = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_valid, a_abort, b_valid, b_abort;
  logic [1:0] a_op, b_op;
  logic [4:0] a_addr, b_addr;

  wire a_ready, a_v1, a_done, a_aborted, b_ready, b_v1, b_done, b_aborted;
  wire [4:0] a_dv, a_dvn, a_sel, b_dv, b_dvn, b_sel;
  wire [2:0] a_stb, b_stb;

  // {dv[4:0], dvn[4:0], LGAV PCG2V DARA DARO PARSV, X3 W8 Y8, done, aborted, cmd_ready}
  wire [20:0] obs_a = {a_dv, a_dvn, a_sel, a_stb, a_done, a_aborted, a_ready};
  wire [20:0] obs_b = {b_dv, b_dvn, b_sel, b_stb, b_done, b_aborted, b_ready};

  pio_command_issuer dut_a (
    .SIM_CLK(clk), .SIM_RST(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_op(a_op), .cmd_addr(a_addr), .cmd_abort(a_abort), .V1(a_v1),
    .A3DV(a_dv[0]), .A4DV(a_dv[1]), .A5DV(a_dv[2]), .A6DV(a_dv[3]), .A7DV(a_dv[4]),
    .A3DVN(a_dvn[0]), .A4DVN(a_dvn[1]), .A5DVN(a_dvn[2]), .A6DVN(a_dvn[3]), .A7DVN(a_dvn[4]),
    .LGAV(a_sel[4]), .PCG2V(a_sel[3]), .DARA(a_sel[2]), .DARO(a_sel[1]), .PARSV(a_sel[0]),
    .X3(a_stb[2]), .W8(a_stb[1]), .Y8(a_stb[0]), .done(a_done), .aborted(a_aborted)
  );

  pio_command_issuer #(.PHASE_CYCLES(2), .NUM_BITS(NB)) dut_b (
    .SIM_CLK(clk), .SIM_RST(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_addr(b_addr), .cmd_abort(b_abort), .V1(b_v1),
    .A3DV(b_dv[0]), .A4DV(b_dv[1]), .A5DV(b_dv[2]), .A6DV(b_dv[3]), .A7DV(b_dv[4]),
    .A3DVN(b_dvn[0]), .A4DVN(b_dvn[1]), .A5DVN(b_dvn[2]), .A6DVN(b_dvn[3]), .A7DVN(b_dvn[4]),
    .LGAV(b_sel[4]), .PCG2V(b_sel[3]), .DARA(b_sel[2]), .DARO(b_sel[1]), .PARSV(b_sel[0]),
    .X3(b_stb[2]), .W8(b_stb[1]), .Y8(b_stb[0]), .done(b_done), .aborted(b_aborted)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [20:0] q_a[$];
  logic [20:0] q_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
  endtask

  // Expected output vector at a given ACTIVE offset, straight from the slot formulas
  function automatic logic [20:0] exp_word(input int op, input logic [4:0] addr,
                                           input int pc, input int k);
    logic [4:0] sel;
    logic [2:0] stb;
    int s;
    case (op)
      0:       begin sel = 5'b11000; stb = 3'b100; s = ((3 - 1) * 4 + 1) * pc; end
      1:       begin sel = 5'b00100; stb = 3'b010; s = ((8 - 1) * 4 + 0) * pc; end
      2:       begin sel = 5'b00010; stb = 3'b001; s = ((8 - 1) * 4 + 2) * pc; end
      default: begin sel = 5'b00001; stb = 3'b010; s = ((8 - 1) * 4 + 0) * pc; end
    endcase
    if (!(k >= s && k < s + pc)) stb = 3'b000;
    return {addr, ~addr, sel, stb, 3'b000};
  endfunction

  task automatic push_word(input bit to_b, input int op, input logic [4:0] addr,
                           input int pc, input int n_off, input bit with_done);
    for (int k = 0; k < n_off; k++) begin
      if (to_b) q_b.push_back(exp_word(op, addr, pc, k));
      else      q_a.push_back(exp_word(op, addr, pc, k));
    end
    if (with_done) begin
      if (to_b) q_b.push_back(21'd5);
      else      q_a.push_back(21'd5);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q_a.size() > 0) check("word_a", obs_a, q_a.pop_front());
  end

  always @(posedge clk) begin
    #1;
    if (q_b.size() > 0) check("word_b", obs_b, q_b.pop_front());
  end

  task automatic wait_drain();
    int t = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain", q_a.size() + q_b.size(), 0);
  endtask

  task automatic issue_a(input int op, input logic [4:0] addr);
    push_word(1'b0, op, addr, 1, NB * 4, 1'b1);
    a_valid = 1'b1;
    a_op    = 2'(op);
    a_addr  = addr;
    @(negedge clk);
    a_valid = 1'b0;
    a_addr  = 5'($urandom);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_abort = 1'b0; a_op = 2'd0; a_addr = 5'd0;
    b_valid = 1'b0; b_abort = 1'b0; b_op = 2'd0; b_addr = 5'd0;

    // Reset and V1 bring-up
    repeat (3) @(negedge clk);
    a_valid = 1'b1;
    @(negedge clk);
    check("rst_outs_a", obs_a, 0);
    check("rst_outs_b", obs_b, 0);
    check("rst_v1", {a_v1, b_v1}, 0);
    a_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("v1_edge1", {a_v1, a_ready}, 2'b00);
    @(posedge clk); #1;
    check("v1_edge2", {a_v1, a_ready, b_v1, b_ready}, 4'b1111);
    @(negedge clk);

    // LATCH, default timing
    issue_a(0, 5'b00101);
    wait_drain();

    // CLEAR aborted on the W8 slot
    push_word(1'b0, 3, 5'b11010, 1, 29, 1'b0);
    q_a.push_back(21'd3);
    q_a.push_back(21'd1);
    a_valid = 1'b1; a_op = 2'd3; a_addr = 5'b11010;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (28) @(negedge clk);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    wait_drain();

    // Reset mid-word, then a clean restart
    push_word(1'b0, 0, 5'b01011, 1, 20, 1'b0);
    a_valid = 1'b1; a_op = 2'd0; a_addr = 5'b01011;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("q_flush", q_a.size(), 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_a", obs_a, 0);
    check("rst_mid_b", obs_b, 0);
    check("rst_mid_v1", a_v1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue_a(2, 5'b10011);
    wait_drain();

    // cmd_valid held with changing addr while busy
    push_word(1'b0, 0, 5'b10110, 1, NB * 4, 1'b1);
    push_word(1'b0, 2, 5'b01001, 1, NB * 4, 1'b1);
    a_valid = 1'b1; a_op = 2'd0; a_addr = 5'b10110;
    for (int i = 0; i < NB * 4; i++) begin
      @(negedge clk);
      a_addr = 5'($urandom);
      a_op   = 2'($urandom);
    end
    @(negedge clk);
    a_op = 2'd2; a_addr = 5'b01001;
    @(negedge clk);
    a_valid = 1'b0;
    wait_drain();

    // DARO_WR then DARA_WR back-to-back, PHASE_CYCLES=2
    push_word(1'b1, 2, 5'b11100, 2, NB * 8, 1'b1);
    push_word(1'b1, 1, 5'b00011, 2, NB * 8, 1'b1);
    b_valid = 1'b1; b_op = 2'd2; b_addr = 5'b11100;
    @(negedge clk);
    b_op = 2'd1; b_addr = 5'b00011;
    repeat (NB * 8 + 1) @(negedge clk);
    b_valid = 1'b0;
    wait_drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
